// File: rtl/gslcd_fb_rd_responder.sv
// AXI4 read-only INCR burst responder serving the LCD framebuffer from a sync-read RAM.
// state | meaning
// IDLE  | arready high, waiting for an AR handshake
// BURST | issuing RAM reads and returning R beats until the RLAST handshake
module gslcd_fb_rd_responder #(
    parameter int          C_S00_AXI_ID_WIDTH   = 1,
    parameter int          C_S00_AXI_ADDR_WIDTH = 32,
    parameter int          C_S00_AXI_DATA_WIDTH = 32,
    parameter logic [63:0] C_MEM_BASE           = 64'd0,
    parameter int          C_MEM_WORDS          = 288000,
    parameter int          C_MEM_ADDR_WIDTH     = 19
) (
    input  logic                            s00_axi_aclk,
    input  logic                            s00_axi_areset,
    input  logic [C_S00_AXI_ID_WIDTH-1:0]   s00_axi_arid,
    input  logic [C_S00_AXI_ADDR_WIDTH-1:0] s00_axi_araddr,
    input  logic [7:0]                      s00_axi_arlen,
    input  logic [2:0]                      s00_axi_arsize,
    input  logic [1:0]                      s00_axi_arburst,
    input  logic                            s00_axi_arvalid,
    output logic                            s00_axi_arready,
    output logic [C_S00_AXI_ID_WIDTH-1:0]   s00_axi_rid,
    output logic [C_S00_AXI_DATA_WIDTH-1:0] s00_axi_rdata,
    output logic [1:0]                      s00_axi_rresp,
    output logic                            s00_axi_rlast,
    output logic                            s00_axi_rvalid,
    input  logic                            s00_axi_rready,
    output logic                            mem_en,
    output logic [C_MEM_ADDR_WIDTH-1:0]     mem_addr,
    input  logic [C_S00_AXI_DATA_WIDTH-1:0] mem_rdata
);

    localparam int IDW = C_S00_AXI_ID_WIDTH;
    localparam int AW  = C_S00_AXI_ADDR_WIDTH;
    localparam int DW  = C_S00_AXI_DATA_WIDTH;
    localparam int LSB = $clog2(DW / 8);
    // one spare bit so w+n past the top of the address space still compares as out of range
    localparam int WW  = AW + 1;

    localparam logic [AW-1:0] MEM_BASE  = C_MEM_BASE[AW-1:0];
    localparam logic [WW-1:0] MEM_WORDS = WW'(C_MEM_WORDS);

    typedef enum logic {S_IDLE, S_BURST} state_t;

    state_t          state_q, state_d;
    logic            arready_q;
    logic [IDW-1:0]  id_q;
    logic [WW-1:0]   word_q;
    logic [8:0]      beats_q;
    logic            below_q, err_q;
    logic            infl_v_q, infl_bad_q, infl_last_q;
    logic [DW-1:0]   fifo_data_q [2];
    logic            fifo_slv_q  [2];
    logic            fifo_last_q [2];
    logic            rd_ptr_q, wr_ptr_q;
    logic [1:0]      count_q;

    logic            ar_hs, pop, push, issue, beat_bad, last_issue, rlast_hs;
    logic [2:0]      occ;

    assign ar_hs      = s00_axi_arvalid & arready_q;
    assign pop        = (count_q != 2'd0) & s00_axi_rready;
    assign push       = infl_v_q;
    assign occ        = {1'b0, count_q} + {2'b00, infl_v_q} - {2'b00, pop};
    assign beat_bad   = err_q | below_q | (word_q >= MEM_WORDS);
    assign last_issue = (beats_q == 9'd1);
    assign issue      = (state_q == S_BURST) & (beats_q != 9'd0) & (occ < 3'd2);
    assign rlast_hs   = pop & fifo_last_q[rd_ptr_q];

    assign mem_en   = issue & ~beat_bad;
    assign mem_addr = word_q[C_MEM_ADDR_WIDTH-1:0];

    assign s00_axi_arready = arready_q;
    assign s00_axi_rid     = id_q;
    assign s00_axi_rvalid  = (count_q != 2'd0);
    assign s00_axi_rdata   = s00_axi_rvalid ? fifo_data_q[rd_ptr_q] : '0;
    assign s00_axi_rresp   = {s00_axi_rvalid & fifo_slv_q[rd_ptr_q], 1'b0};
    assign s00_axi_rlast   = s00_axi_rvalid & fifo_last_q[rd_ptr_q];

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (ar_hs)    state_d = S_BURST;
            S_BURST: if (rlast_hs) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
        if (s00_axi_areset) begin
            state_q   <= S_IDLE;
            arready_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            arready_q <= (state_d == S_IDLE);
        end
    end

    // burst context: beats_q counts down the beats still to be issued to the RAM
    always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
        if (s00_axi_areset) begin
            id_q    <= '0;
            word_q  <= '0;
            beats_q <= '0;
            below_q <= 1'b0;
            err_q   <= 1'b0;
        end else if (ar_hs) begin
            id_q    <= s00_axi_arid;
            word_q  <= WW'((s00_axi_araddr - MEM_BASE) >> LSB);
            beats_q <= {1'b0, s00_axi_arlen} + 9'd1;
            below_q <= (s00_axi_araddr < MEM_BASE);
            err_q   <= (s00_axi_arburst != 2'b01) | (s00_axi_arsize != 3'(LSB));
        end else if (issue) begin
            word_q  <= word_q + 1'b1;
            beats_q <= beats_q - 9'd1;
        end
    end

    always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
        if (s00_axi_areset) begin
            infl_v_q    <= 1'b0;
            infl_bad_q  <= 1'b0;
            infl_last_q <= 1'b0;
        end else begin
            infl_v_q    <= issue;
            infl_bad_q  <= beat_bad;
            infl_last_q <= last_issue;
        end
    end

    // issue throttling guarantees a push never lands on a full FIFO
    always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
        if (s00_axi_areset) begin
            for (int i = 0; i < 2; i++) begin
                fifo_data_q[i] <= '0;
                fifo_slv_q[i]  <= 1'b0;
                fifo_last_q[i] <= 1'b0;
            end
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push) begin
                fifo_data_q[wr_ptr_q] <= infl_bad_q ? '0 : mem_rdata;
                fifo_slv_q[wr_ptr_q]  <= infl_bad_q;
                fifo_last_q[wr_ptr_q] <= infl_last_q;
                wr_ptr_q              <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule
